stream_mux_2_to_1: RTL and testbench

Merges two valid/ready input streams, A and B, onto one registered output stream, tagging each beat with its source. It is the merge-side counterpart of the 1-to-2 demultiplexer: a beat the demux steers out by `sel` can be brought back together here, with `y_sel` reproducing the steering bit. Arbitration is round-robin, and a single-entry output register gives full throughput and one cycle of latency.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/mux2_rr_arbiter.sv | 64 ++++++
 rtl/stream_mux_2_to_1.sv | 143 ++++++++++++++
 tb/tb_stream_mux_2_to_1.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the 2-to-1 round-robin stream merge.
// The packet-lock state type is only consumed when STREAM_MUX_LOCK_EN is defined.
package stream_mux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } lock_state_t;

endpackage

// File: rtl/mux2_rr_arbiter.sv
// Combinational two-way round-robin arbiter with one-hot grant.
// With STREAM_MUX_LOCK_EN defined, a packet lock restricts the grant to the locked source.
module mux2_rr_arbiter
    import stream_mux_pkg::*;
(
    input  logic        i_req_a,
    input  logic        i_req_b,
    input  logic        i_last_b,
`ifdef STREAM_MUX_LOCK_EN
    input  lock_state_t i_lock_state,
`endif
    output logic        o_gnt_a,
    output logic        o_gnt_b
);

    logic w_rr_gnt_a;
    logic w_rr_gnt_b;

    // Plain round-robin: on contention, the source not served last wins.
    always_comb begin
        w_rr_gnt_a = 1'b0;
        w_rr_gnt_b = 1'b0;
        if (i_req_a && i_req_b) begin
            w_rr_gnt_a = i_last_b;
            w_rr_gnt_b = !i_last_b;
        end else begin
            w_rr_gnt_a = i_req_a;
            w_rr_gnt_b = i_req_b;
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    // A locked packet excludes the other source even while the owner is idle.
    always_comb begin
        o_gnt_a = 1'b0;
        o_gnt_b = 1'b0;
        case (i_lock_state)
            LOCK_A: begin
                o_gnt_a = i_req_a;
                o_gnt_b = 1'b0;
            end
            LOCK_B: begin
                o_gnt_a = 1'b0;
                o_gnt_b = i_req_b;
            end
            IDLE: begin
                o_gnt_a = w_rr_gnt_a;
                o_gnt_b = w_rr_gnt_b;
            end
            default: begin
                o_gnt_a = 1'b0;
                o_gnt_b = 1'b0;
            end
        endcase
    end
`else
    // Without packet lock the round-robin result is the grant.
    always_comb begin
        o_gnt_a = w_rr_gnt_a;
        o_gnt_b = w_rr_gnt_b;
    end
`endif

endmodule

// File: rtl/stream_mux_2_to_1.sv
// Merges valid/ready streams A and B into one registered stream tagged with its source.
// Optional packet lock (y_last, i_*_last) is built when STREAM_MUX_LOCK_EN is defined.
module stream_mux_2_to_1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef STREAM_MUX_LOCK_EN
    input  logic             i_a_last,
    input  logic             i_b_last,
    output logic             o_y_last,
`endif
    input  logic             i_a_valid,
    input  logic [WIDTH-1:0] i_a_data,
    output logic             o_a_ready,
    input  logic             i_b_valid,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_b_ready,
    output logic             o_y_valid,
    output logic [WIDTH-1:0] o_y_data,
    output logic             o_y_sel,
    input  logic             i_y_ready
);

    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    logic             r_y_sel;
    logic             r_last_b;
    logic             w_load_ok;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_acc_a;
    logic             w_acc_b;

`ifdef STREAM_MUX_LOCK_EN
    lock_state_t      r_lock_state;
    lock_state_t      w_lock_next;
    logic             r_y_last;
`endif

    mux2_rr_arbiter u_arb (
        .i_req_a      (i_a_valid),
        .i_req_b      (i_b_valid),
        .i_last_b     (r_last_b),
`ifdef STREAM_MUX_LOCK_EN
        .i_lock_state (r_lock_state),
`endif
        .o_gnt_a      (w_gnt_a),
        .o_gnt_b      (w_gnt_b)
    );

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        w_load_ok = !r_y_valid || i_y_ready;
        w_acc_a   = rst_n && w_load_ok && w_gnt_a && i_a_valid;
        w_acc_b   = rst_n && w_load_ok && w_gnt_b && i_b_valid;
        o_a_ready = rst_n && w_load_ok && w_gnt_a;
        o_b_ready = rst_n && w_load_ok && w_gnt_b;
    end

    // Output register: load overwrites even while draining, so there is no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_valid <= 1'b0;
            r_y_data  <= {WIDTH{1'b0}};
            r_y_sel   <= SEL_A;
            r_last_b  <= 1'b1;
        end else if (w_acc_a) begin
            r_y_valid <= 1'b1;
            r_y_data  <= i_a_data;
            r_y_sel   <= SEL_A;
            r_last_b  <= SEL_A;
        end else if (w_acc_b) begin
            r_y_valid <= 1'b1;
            r_y_data  <= i_b_data;
            r_y_sel   <= SEL_B;
            r_last_b  <= SEL_B;
        end else if (i_y_ready) begin
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= r_y_valid;
        end
    end

    assign o_y_valid = r_y_valid;
    assign o_y_data  = r_y_data;
    assign o_y_sel   = r_y_sel;

`ifdef STREAM_MUX_LOCK_EN
    // Lock next-state: enter on a non-last beat, leave on the owner's last beat.
    always_comb begin
        w_lock_next = r_lock_state;
        case (r_lock_state)
            IDLE: begin
                if (w_acc_a && !i_a_last) begin
                    w_lock_next = LOCK_A;
                end else if (w_acc_b && !i_b_last) begin
                    w_lock_next = LOCK_B;
                end else begin
                    w_lock_next = IDLE;
                end
            end
            LOCK_A: begin
                if (w_acc_a && i_a_last) begin
                    w_lock_next = IDLE;
                end else begin
                    w_lock_next = LOCK_A;
                end
            end
            LOCK_B: begin
                if (w_acc_b && i_b_last) begin
                    w_lock_next = IDLE;
                end else begin
                    w_lock_next = LOCK_B;
                end
            end
            default: w_lock_next = IDLE;
        endcase
    end

    // Lock state register and the last flag that travels with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_state <= IDLE;
            r_y_last     <= 1'b0;
        end else begin
            r_lock_state <= w_lock_next;
            if (w_acc_a) begin
                r_y_last <= i_a_last;
            end else if (w_acc_b) begin
                r_y_last <= i_b_last;
            end else begin
                r_y_last <= r_y_last;
            end
        end
    end

    assign o_y_last = r_y_last;
`endif

endmodule

// File: tb/tb_stream_mux_2_to_1.sv
// Self-checking bench for stream_mux_2_to_1: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_stream_mux_2_to_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_v = 1'b0, b_v = 1'b0, y_rdy = 1'b0;
    logic [7:0] a_d = 8'h00, b_d = 8'h00;
    logic       a_rdy, b_rdy, y_v, y_s;
    logic [7:0] y_d;
`ifdef STREAM_MUX_LOCK_EN
    logic       a_l = 1'b0, b_l = 1'b0;
    logic       y_l;
`endif

    int total = 0;
    int bad = 0;

    // Model: held beat plus which source was served last and packet owner
    bit         m_valid;
    logic [7:0] m_data;
    bit         m_sel;
    bit         m_served_b;
    bit         m_last;
    int         m_owner;      // 0 none, 1 A, 2 B
    bit         acc_a, acc_b;

    always #5 clk = ~clk;

    stream_mux_2_to_1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef STREAM_MUX_LOCK_EN
        .i_a_last  (a_l),
        .i_b_last  (b_l),
        .o_y_last  (y_l),
`endif
        .i_a_valid (a_v),
        .i_a_data  (a_d),
        .o_a_ready (a_rdy),
        .i_b_valid (b_v),
        .i_b_data  (b_d),
        .o_b_ready (b_rdy),
        .o_y_valid (y_v),
        .o_y_data  (y_d),
        .o_y_sel   (y_s),
        .i_y_ready (y_rdy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = 8'h00; m_sel = 1'b0; m_served_b = 1'b1;
        m_last = 1'b0; m_owner = 0; acc_a = 1'b0; acc_b = 1'b0;
    endtask

    // One cycle: inputs already driven; check, clock, advance model.
    task automatic step();
        bit wa, wb, room, ea, eb;
        #1;
        wa = 1'b0; wb = 1'b0;
        if (m_owner == 1)      wa = a_v;
        else if (m_owner == 2) wb = b_v;
        else if (a_v && b_v) begin
            if (m_served_b) wa = 1'b1; else wb = 1'b1;
        end else begin
            wa = a_v; wb = b_v;
        end
        room = !m_valid || y_rdy;
        ea = rst_n && room && wa;
        eb = rst_n && room && wb;
        chk("a_ready", a_rdy, ea);
        chk("b_ready", b_rdy, eb);
        chk("y_valid", y_v, m_valid);
        chk("y_data", y_d, m_data);
        chk("y_sel", y_s, m_sel);
`ifdef STREAM_MUX_LOCK_EN
        chk("y_last", y_l, m_last);
`endif
        @(posedge clk);
        if (ea) begin
            m_valid = 1'b1; m_data = a_d; m_sel = 1'b0; m_served_b = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
            m_last = a_l;
            if (m_owner == 0 && !a_l) m_owner = 1;
            else if (m_owner == 1 && a_l) m_owner = 0;
`endif
        end else if (eb) begin
            m_valid = 1'b1; m_data = b_d; m_sel = 1'b1; m_served_b = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
            m_last = b_l;
            if (m_owner == 0 && !b_l) m_owner = 2;
            else if (m_owner == 2 && b_l) m_owner = 0;
`endif
        end else if (y_rdy) begin
            m_valid = 1'b0;
        end
        acc_a = ea; acc_b = eb;
        @(negedge clk);
    endtask

    // Pending beats stay stable until accepted; otherwise pick new traffic.
    task automatic rand_inputs();
        if (!(a_v && !acc_a)) begin
            a_v = 1'($urandom_range(0, 1));
            a_d = 8'($urandom);
`ifdef STREAM_MUX_LOCK_EN
            a_l = ($urandom_range(0, 2) == 0);
`endif
        end
        if (!(b_v && !acc_b)) begin
            b_v = 1'($urandom_range(0, 1));
            b_d = 8'($urandom);
`ifdef STREAM_MUX_LOCK_EN
            b_l = ($urandom_range(0, 2) == 0);
`endif
        end
        y_rdy = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        a_v = 1'b1; a_d = 8'h11; b_v = 1'b1; b_d = 8'h22; y_rdy = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
        a_l = 1'b1; b_l = 1'b1;
`endif
        @(negedge clk);
        #1;
        chk("rst_y_valid", y_v, 32'd0);
        chk("rst_a_ready", a_rdy, 32'd0);
        chk("rst_b_ready", b_rdy, 32'd0);
        chk("rst_y_data", y_d, 32'd0);
        rst_n = 1'b1;

        // Both valid: alternation A,B,A,... with no bubble
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alt_y_valid", y_v, 32'd1);
            chk("alt_y_sel", y_s, 32'(i % 2));
            if (i == 0) chk("first_y_data", y_d, 32'h11);
            if (i == 1) chk("second_y_data", y_d, 32'h22);
            if (acc_a) a_d = a_d + 8'h10;
            if (acc_b) b_d = b_d + 8'h10;
        end

        // B alone for four beats, then A wins the contest
        a_v = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            b_d = 8'(k);
            step();
            chk("bonly_y_data", y_d, 32'(k));
            chk("bonly_y_sel", y_s, 32'd1);
        end
        a_v = 1'b1; a_d = 8'h77; b_d = 8'h05;
        step();
        chk("a_after_b_sel", y_s, 32'd0);
        chk("a_after_b_data", y_d, 32'h77);

        // Stall with 0x5A held, then drain and reload on one edge
        a_d = 8'h5A; b_v = 1'b0;
        step();
        a_v = 1'b0; b_v = 1'b1; b_d = 8'h66; y_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_y_data", y_d, 32'h5A);
            chk("stall_a_ready", a_rdy, 32'd0);
            chk("stall_b_ready", b_rdy, 32'd0);
        end
        y_rdy = 1'b1;
        step();
        chk("reload_y_data", y_d, 32'h66);
        chk("reload_y_valid", y_v, 32'd1);

        // Asynchronous reset while full
        #2 rst_n = 1'b0;
        #1 chk("async_rst_y_valid", y_v, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        a_v = 1'b1; a_d = 8'h31; b_v = 1'b1; b_d = 8'h42; y_rdy = 1'b1;
        step();
        chk("post_rst_sel", y_s, 32'd0);
        chk("post_rst_data", y_d, 32'h31);

`ifdef STREAM_MUX_LOCK_EN
        // Three-beat A packet holds off a waiting B
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        b_v = 1'b1; b_d = 8'hB0; b_l = 1'b1; a_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_d = 8'(8'hA1 + k); a_l = (k == 2);
            step();
            chk("lock_sel", y_s, 32'd0);
            chk("lock_data", y_d, 32'(8'hA1 + k));
            chk("lock_last", y_l, 32'(k == 2));
        end
        a_v = 1'b0;
        step();
        chk("lock_then_b", y_s, 32'd1);
        chk("lock_then_b_data", y_d, 32'hB0);
`endif

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
